dmem_dump_tx: RTL and testbench

// Readback counterpart of the UART program loader: when started, reads a range
// of data-memory words and serialises them out of TXD as 8N1 UART frames.

---
 rtl/dmem_dump_tx.sv | 147 ++++++++++++++
 tb/tb_dmem_dump_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_tx.sv
// dmem_dump_tx: streams a range of data-memory words out of a UART TX pin.
// A host starts it after a program run to read results back. Each word is
// fetched through dmem's synchronous read port and sent as four 8N1 frames,
// least-significant byte first.
module dmem_dump_tx #(
  parameter int CLK_DIV  = 868,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [CNT_W-1:0]    num_words,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic                rd_en,
  input  logic [DATA_LEN-1:0] rd_data,
  output logic                txd,
  output logic                busy,
  output logic                done
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [1:0]          byte_idx;
  logic [CNT_W-1:0]    remaining;
  logic [DATA_LEN-1:0] shift_word;
  logic                baud_last;

  // Word alignment drops the two low address bits on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^base_addr[1:0];

  assign baud_last = (baud_cnt == BAUD_LAST);

  // Transfer FSM: rd_addr doubles as the running word address, the shift word
  // is consumed one bit at a time so the next byte always sits in bits [7:0].
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      remaining  <= '0;
      shift_word <= '0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old transfer.
          if (start && !done) begin
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              rd_addr   <= {base_addr[ADDR_LEN-1:2], 2'b00};
              remaining <= num_words;
              rd_en     <= 1'b1;
              busy      <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_word <= rd_data;
          byte_idx   <= '0;
          bit_idx    <= '0;
          baud_cnt   <= '0;
          txd        <= 1'b0;
          state      <= START;
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift_word[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt   <= '0;
            shift_word <= shift_word >> 1;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift_word[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 1'b1;
              txd      <= 1'b0;
              state    <= START;
            end else if (remaining > CNT_W'(1)) begin
              remaining <= remaining - 1'b1;
              rd_addr   <= rd_addr + ADDR_LEN'(4);
              rd_en     <= 1'b1;
              state     <= READ;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_tx.sv
// tb_dmem_dump_tx: directed and randomized transfers against a cycle-level
// waveform model built from the frame format (2 idle cycles per word, then
// four 10-bit frames of CLK_DIV cycles each, done one cycle after the end).
module tb_dmem_dump_tx;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = 10 * CLK_DIV;
  localparam int WORD_CYC  = 2 + 4 * FRAME_CYC;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic [31:0] rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        txd;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_seed;
  logic [31:0] mem_over [logic [31:0]];

  dmem_dump_tx #(
    .CLK_DIV (CLK_DIV),
    .ADDR_LEN(32),
    .DATA_LEN(32),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .reset_x  (reset_x),
    .start    (start),
    .base_addr(base_addr),
    .num_words(num_words),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .txd      (txd),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory contents: explicit overrides, otherwise a seeded hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // Synchronous-read dmem; garbage on rd_data whenever no read was issued.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem_word(rd_addr) : $urandom();
  end

  // Safety net in case something stalls the directed sequence.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_trace(input string tag, input logic q_act[$], input logic q_exp[$]);
    int d;
    d = -1;
    for (int i = 0; i < q_exp.size(); i++) begin
      if (d < 0 && q_act[i] !== q_exp[i]) d = i;
    end
    n_checks++;
    assert (d === -1) else begin
      n_fail++;
      $error("[TB] FAIL %s: first wrong cycle %0d observed %b expected %b", tag, d, q_act[d], q_exp[d]);
    end
  endtask

  // One transfer: build the expected waveform, drive start, record every cycle
  // after the accept edge, optionally pulse a stray start at cycle hit_idx.
  task automatic applyStimulus(input string tag, input logic [31:0] base, input int n, input int hit_idx);
    logic [31:0] aligned;
    logic [31:0] word;
    logic [7:0]  exp_byte;
    logic [7:0]  got_byte;
    int          total;
    int          len;
    int          st;
    logic        act_txd[$];
    logic        act_busy[$];
    logic        act_done[$];
    logic        act_rden[$];
    logic        exp_txd[$];
    logic        exp_busy[$];
    logic        exp_done[$];
    logic        exp_rden[$];
    logic [31:0] act_addr[$];

    aligned = {base[31:2], 2'b00};
    len     = n * WORD_CYC;
    total   = len + 4;

    for (int w = 0; w < n; w++) begin
      word = mem_word(aligned + 32'(4 * w));
      exp_txd.push_back(1'b1);
      exp_txd.push_back(1'b1);
      for (int k = 0; k < 4; k++) begin
        exp_byte = word[8*k +: 8];
        repeat (CLK_DIV) exp_txd.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (CLK_DIV) exp_txd.push_back(exp_byte[b]);
        repeat (CLK_DIV) exp_txd.push_back(1'b1);
      end
    end
    while (exp_txd.size() < total) exp_txd.push_back(1'b1);
    for (int i = 0; i < total; i++) begin
      exp_busy.push_back(i < len);
      exp_done.push_back(i == len);
      exp_rden.push_back(i < len && (i % WORD_CYC) == 0);
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    num_words = 16'(n);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      act_txd.push_back(txd);
      act_busy.push_back(busy);
      act_done.push_back(done);
      act_rden.push_back(rd_en);
      if (rd_en === 1'b1) act_addr.push_back(rd_addr);
      start = 1'b0;
      if (i == 0) begin
        base_addr = $urandom();
        num_words = 16'($urandom());
      end
      if (i == hit_idx) begin
        start     = 1'b1;
        base_addr = $urandom();
        num_words = 16'($urandom_range(1, 4));
      end
    end

    check_trace({tag, " txd"}, act_txd, exp_txd);
    check_trace({tag, " busy"}, act_busy, exp_busy);
    check_trace({tag, " done"}, act_done, exp_done);
    check_trace({tag, " rd_en"}, act_rden, exp_rden);
    checkOutput({tag, " read count"}, 32'(act_addr.size()), 32'(n));
    for (int w = 0; w < n && w < act_addr.size(); w++) begin
      checkOutput($sformatf("%s rd_addr[%0d]", tag, w), act_addr[w], aligned + 32'(4 * w));
    end
    for (int w = 0; w < n; w++) begin
      word = mem_word(aligned + 32'(4 * w));
      for (int k = 0; k < 4; k++) begin
        st = w * WORD_CYC + 2 + k * FRAME_CYC;
        for (int b = 0; b < 8; b++) got_byte[b] = act_txd[st + CLK_DIV * (b + 1) + CLK_DIV / 2];
        exp_byte = word[8*k +: 8];
        checkOutput($sformatf("%s byte w%0d k%0d", tag, w, k), 32'(got_byte), 32'(exp_byte));
      end
    end
  endtask

  // Directed sequence followed by a few randomized transfers.
  initial begin
    int          cnt_done;
    int          cnt_low;
    int          cnt_busy;
    logic [31:0] rb;
    int          rn;

    mem_seed  = $urandom();
    reset_x   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset txd", 32'(txd), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset rd_en", 32'(rd_en), 32'd0);
    checkOutput("reset rd_addr", rd_addr, 32'd0);
    reset_x = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] async reset mid-DATA");
    mem_over[32'h40] = 32'h1234_5600;
    start     = 1'b1;
    base_addr = 32'h40;
    num_words = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("pre-reset txd low", 32'(txd), 32'd0);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    #2;
    reset_x = 1'b0;
    #1;
    checkOutput("async reset txd", 32'(txd), 32'd1);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset done", 32'(done), 32'd0);
    checkOutput("async reset rd_en", 32'(rd_en), 32'd0);
    @(negedge clk);
    reset_x  = 1'b1;
    cnt_done = 0;
    cnt_low  = 0;
    cnt_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0) cnt_done++;
      if (txd !== 1'b1) cnt_low++;
      if (busy !== 1'b0) cnt_busy++;
    end
    checkOutput("post-reset done cycles", 32'(cnt_done), 32'd0);
    checkOutput("post-reset txd low cycles", 32'(cnt_low), 32'd0);
    checkOutput("post-reset busy cycles", 32'(cnt_busy), 32'd0);

    $display("[TB] single word");
    mem_over[32'h10] = 32'hA5C3_0F81;
    applyStimulus("single", 32'h10, 1, -1);

    $display("[TB] multi-word with start on the done cycle");
    applyStimulus("multi", 32'h0, 3, 3 * WORD_CYC);

    $display("[TB] zero length and misaligned base");
    applyStimulus("zero", 32'h20, 0, -1);
    applyStimulus("misaligned", 32'h13, 1, -1);

    $display("[TB] start while busy");
    applyStimulus("busy-start", 32'h100, 2, 100);

    $display("[TB] address wrap");
    applyStimulus("wrap", 32'hFFFF_FFFC, 2, -1);

    $display("[TB] randomized transfers");
    for (int r = 0; r < 3; r++) begin
      rb = $urandom();
      rn = $urandom_range(1, 3);
      applyStimulus($sformatf("rand%0d", r), rb, rn, $urandom_range(1, rn * WORD_CYC));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
